cc_hitmiss_dispatcher: RTL and testbench

Cache-controller scheduler that sits between the tag-lookup stage and the data reorder unit. It accepts one lookup result per handshake and records request order by pushing a hit/miss flag. On a hit it pushes the line and offset into the hit-data FIFO; on a miss it issues a 64-byte AXI read burst to memory. It throttles lookups on FIFO almost-full and on a cap of outstanding misses, so the reorder unit never overflows and never waits on an unissued miss.

---
 rtl/cc_pkg.sv | 16 +
 rtl/cc_outstanding_ctr.sv | 52 +++++
 rtl/cc_hitmiss_dispatcher.sv | 150 +++++++++++++++
 tb/tb_cc_hitmiss_dispatcher.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared types and constants for the hit/miss dispatcher slice.
package cc_pkg;

    localparam int          CC_LINE_W     = 512;
    localparam int          CC_OFFSET_W   = 6;
    localparam int          CC_HIT_DATA_W = 518;
    localparam logic [3:0]  CC_BURST_LEN  = 4'd7;
    // Wide enough for MAX_OUTSTANDING up to 15.
    localparam int          CC_OUT_CTR_W  = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        MISS_AR = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_outstanding_ctr.sv
// Up/down counter of in-flight misses. It saturates at 0 and at MAX_COUNT,
// and flags full when MAX_COUNT misses are outstanding.
module cc_outstanding_ctr
    import cc_pkg::*;
#(
    parameter int MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o
);

    logic [CC_OUT_CTR_W-1:0] count_q;
    logic [CC_OUT_CTR_W-1:0] count_d;

    // Next count: simultaneous inc and dec cancel; the ends saturate.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (count_q < CC_OUT_CTR_W'(MAX_COUNT)) begin
                count_d = count_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_o = (count_q >= CC_OUT_CTR_W'(MAX_COUNT));

`ifndef SYNTHESIS
    // A final R beat with nothing outstanding means the memory side misbehaved.
    always_ff @(posedge clk) begin
        if (rst_n && dec_i && !inc_i) begin
            assert (count_q != '0);
        end
    end
`endif

endmodule

// File: rtl/cc_hitmiss_dispatcher.sv
// Dispatches tag-lookup results. Every accepted lookup writes its hit/miss
// flag. A hit writes the data FIFO, and a miss issues one AXI read burst.
// Lookups are throttled on FIFO almost-full and on the outstanding-miss cap.
// Optional hit/miss performance counters: CC_DISPATCH_PERF_CNT_EN.
module cc_hitmiss_dispatcher
    import cc_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lk_valid_i,
    output logic                     lk_ready_o,
    input  logic                     lk_hit_i,
    input  logic [ADDR_W-1:0]        lk_addr_i,
    input  logic [CC_LINE_W-1:0]     lk_line_i,
    input  logic                     hit_flag_fifo_afull_i,
    output logic                     hit_flag_fifo_wren_o,
    output logic                     hit_flag_fifo_wdata_o,
    input  logic                     hit_data_fifo_afull_i,
    output logic                     hit_data_fifo_wren_o,
    output logic [CC_HIT_DATA_W-1:0] hit_data_fifo_wdata_o,
    output logic [ADDR_W-1:0]        mem_araddr_o,
    output logic [3:0]               mem_arlen_o,
    output logic                     mem_arvalid_o,
    input  logic                     mem_arready_i,
    input  logic                     mem_rvalid_i,
    input  logic                     mem_rready_i,
    input  logic                     mem_rlast_i,
    output logic [CNT_W-1:0]         hit_cnt_o,
    output logic [CNT_W-1:0]         miss_cnt_o
);

    cc_state_e                state_q, state_d;
    logic                     flag_wren_q, flag_wren_d;
    logic                     flag_wdata_q, flag_wdata_d;
    logic                     data_wren_q, data_wren_d;
    logic [CC_HIT_DATA_W-1:0] data_wdata_q, data_wdata_d;
    logic [ADDR_W-1:0]        araddr_q, araddr_d;

    logic accept;
    logic ar_hs;
    logic retire;
    logic out_full;

    // A miss blocks new lookups until its AR is issued, so flags and AR issue
    // can never reorder.
    assign lk_ready_o = (state_q == IDLE) && !hit_flag_fifo_afull_i &&
                        !hit_data_fifo_afull_i && !out_full;
    assign accept     = lk_valid_i && lk_ready_o;
    assign ar_hs      = (state_q == MISS_AR) && mem_arready_i;
    assign retire     = mem_rvalid_i && mem_rready_i && mem_rlast_i;

    cc_outstanding_ctr #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (ar_hs),
        .dec_i  (retire),
        .full_o (out_full)
    );

    // Next state and the next values of the registered FIFO/AR outputs.
    always_comb begin
        state_d      = state_q;
        flag_wren_d  = 1'b0;
        flag_wdata_d = 1'b0;
        data_wren_d  = 1'b0;
        data_wdata_d = data_wdata_q;
        araddr_d     = araddr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    flag_wren_d  = 1'b1;
                    flag_wdata_d = lk_hit_i;
                    if (lk_hit_i) begin
                        data_wren_d  = 1'b1;
                        data_wdata_d = {lk_addr_i[CC_OFFSET_W-1:0], lk_line_i};
                    end else begin
                        araddr_d = {lk_addr_i[ADDR_W-1:CC_OFFSET_W], {CC_OFFSET_W{1'b0}}};
                        state_d  = MISS_AR;
                    end
                end
            end
            MISS_AR: begin
                if (mem_arready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flag_wren_q  <= 1'b0;
            flag_wdata_q <= 1'b0;
            data_wren_q  <= 1'b0;
            data_wdata_q <= '0;
            araddr_q     <= '0;
        end else begin
            state_q      <= state_d;
            flag_wren_q  <= flag_wren_d;
            flag_wdata_q <= flag_wdata_d;
            data_wren_q  <= data_wren_d;
            data_wdata_q <= data_wdata_d;
            araddr_q     <= araddr_d;
        end
    end

    assign hit_flag_fifo_wren_o  = flag_wren_q;
    assign hit_flag_fifo_wdata_o = flag_wdata_q;
    assign hit_data_fifo_wren_o  = data_wren_q;
    assign hit_data_fifo_wdata_o = data_wdata_q;
    assign mem_arvalid_o         = (state_q == MISS_AR);
    assign mem_araddr_o          = araddr_q;
    assign mem_arlen_o           = CC_BURST_LEN;

`ifdef CC_DISPATCH_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    // Accepted hit/miss counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept && lk_hit_i) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (accept && !lk_hit_i) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cc_hitmiss_dispatcher.sv
// Directed bench for cc_hitmiss_dispatcher.
module tb_cc_hitmiss_dispatcher;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               lk_valid_i;
    logic               lk_ready_o;
    logic               lk_hit_i;
    logic [ADDR_W-1:0]  lk_addr_i;
    logic [511:0]       lk_line_i;
    logic               hit_flag_fifo_afull_i;
    logic               hit_flag_fifo_wren_o;
    logic               hit_flag_fifo_wdata_o;
    logic               hit_data_fifo_afull_i;
    logic               hit_data_fifo_wren_o;
    logic [517:0]       hit_data_fifo_wdata_o;
    logic [ADDR_W-1:0]  mem_araddr_o;
    logic [3:0]         mem_arlen_o;
    logic               mem_arvalid_o;
    logic               mem_arready_i;
    logic               mem_rvalid_i;
    logic               mem_rready_i;
    logic               mem_rlast_i;
    logic [CNT_W-1:0]   hit_cnt_o;
    logic [CNT_W-1:0]   miss_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    cc_hitmiss_dispatcher #(
        .ADDR_W          (ADDR_W),
        .MAX_OUTSTANDING (4),
        .CNT_W           (CNT_W)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .lk_valid_i            (lk_valid_i),
        .lk_ready_o            (lk_ready_o),
        .lk_hit_i              (lk_hit_i),
        .lk_addr_i             (lk_addr_i),
        .lk_line_i             (lk_line_i),
        .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
        .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
        .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
        .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
        .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
        .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
        .mem_araddr_o          (mem_araddr_o),
        .mem_arlen_o           (mem_arlen_o),
        .mem_arvalid_o         (mem_arvalid_o),
        .mem_arready_i         (mem_arready_i),
        .mem_rvalid_i          (mem_rvalid_i),
        .mem_rready_i          (mem_rready_i),
        .mem_rlast_i           (mem_rlast_i),
        .hit_cnt_o             (hit_cnt_o),
        .miss_cnt_o            (miss_cnt_o)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lk_valid_i            = 1'b0;
        lk_hit_i              = 1'b0;
        lk_addr_i             = '0;
        lk_line_i             = '0;
        hit_flag_fifo_afull_i = 1'b0;
        hit_data_fifo_afull_i = 1'b0;
        mem_arready_i         = 1'b0;
        mem_rvalid_i          = 1'b0;
        mem_rready_i          = 1'b0;
        mem_rlast_i           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Bounded wait for lk_ready_o; a timeout counts as a failed comparison.
    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && !lk_ready_o; i++) step();
        n_checks++;
        if (lk_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wait_ready: lk_ready_o=%b required 1 within 20 cycles", name, lk_ready_o);
        end
    endtask

    task automatic pulse_rlast();
        mem_rvalid_i = 1'b1;
        mem_rready_i = 1'b1;
        mem_rlast_i  = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        mem_rready_i = 1'b0;
        mem_rlast_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o, hit_data_fifo_wren_o, mem_arvalid_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 0000",
                     {hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o, hit_data_fifo_wren_o, mem_arvalid_o});
        end
        n_checks++;
        if (hit_data_fifo_wdata_o !== 518'd0 || mem_araddr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: wdata=%h araddr=%h required 0", hit_data_fifo_wdata_o, mem_araddr_o);
        end
        n_checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0 || dut.u_ctr.count_q !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_counters: hit=%0d miss=%0d outst=%0d required 0",
                     hit_cnt_o, miss_cnt_o, dut.u_ctr.count_q);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (lk_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: lk_ready_o=%b required 1", lk_ready_o);
        end
        $display("reset: checks done");
    endtask

    task automatic test_hit();
        logic [517:0] exp_data;
        exp_data   = {6'h28, {64{8'hA5}}};
        lk_valid_i = 1'b1;
        lk_hit_i   = 1'b1;
        lk_addr_i  = 32'h0000_1028;
        lk_line_i  = {64{8'hA5}};
        step();
        lk_valid_i = 1'b0;
        n_checks++;
        if (hit_flag_fifo_wren_o !== 1'b1 || hit_flag_fifo_wdata_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_flag: wren=%b wdata=%b required 1 1", hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o);
        end
        n_checks++;
        if (hit_data_fifo_wren_o !== 1'b1 || hit_data_fifo_wdata_o !== exp_data) begin
            n_fail++;
            $display("FAIL hit_data: wren=%b wdata=%h required 1 %h",
                     hit_data_fifo_wren_o, hit_data_fifo_wdata_o, exp_data);
        end
        n_checks++;
        if (mem_arvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_arvalid: got %b required 0", mem_arvalid_o);
        end
        step();
        n_checks++;
        if (hit_flag_fifo_wren_o !== 1'b0 || hit_data_fifo_wren_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_single_pulse: flag=%b data=%b required 0 0", hit_flag_fifo_wren_o, hit_data_fifo_wren_o);
        end
        $display("hit: addr=0x00001028 line=A5..A5");
    endtask

    task automatic test_miss();
        lk_valid_i    = 1'b1;
        lk_hit_i      = 1'b0;
        lk_addr_i     = 32'h0000_2034;
        mem_arready_i = 1'b0;
        step();
        lk_valid_i = 1'b0;
        n_checks++;
        if (hit_flag_fifo_wren_o !== 1'b1 || hit_flag_fifo_wdata_o !== 1'b0 || hit_data_fifo_wren_o !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_flag: flag wren=%b wdata=%b data wren=%b required 1 0 0",
                     hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o, hit_data_fifo_wren_o);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (mem_arvalid_o !== 1'b1 || mem_araddr_o !== 32'h0000_2000 || mem_arlen_o !== 4'd7 || lk_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_ar_hold[%0d]: arvalid=%b araddr=%h arlen=%0d ready=%b required 1 00002000 7 0",
                         i, mem_arvalid_o, mem_araddr_o, mem_arlen_o, lk_ready_o);
            end
            if (i == 0) begin
                n_checks++;
                if (hit_flag_fifo_wren_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL miss_flag_n1: wren=%b required 1", hit_flag_fifo_wren_o);
                end
            end
            step();
        end
        n_checks++;
        if (hit_flag_fifo_wren_o !== 1'b0 || mem_arvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_hold4: flag wren=%b arvalid=%b required 0 1", hit_flag_fifo_wren_o, mem_arvalid_o);
        end
        mem_arready_i = 1'b1;
        step();
        mem_arready_i = 1'b0;
        n_checks++;
        if (mem_arvalid_o !== 1'b0 || lk_ready_o !== 1'b1 || dut.u_ctr.count_q !== 4'd1) begin
            n_fail++;
            $display("FAIL miss_ar_done: arvalid=%b ready=%b outst=%0d required 0 1 1",
                     mem_arvalid_o, lk_ready_o, dut.u_ctr.count_q);
        end
        pulse_rlast();
        n_checks++;
        if (dut.u_ctr.count_q !== 4'd0) begin
            n_fail++;
            $display("FAIL miss_retire: outst=%0d required 0", dut.u_ctr.count_q);
        end
        $display("miss: addr=0x00002034 araddr=0x00002000");
    endtask

    task automatic test_cap();
        do_reset();
        mem_arready_i = 1'b1;
        for (int m = 0; m < 4; m++) begin
            wait_ready("cap");
            lk_valid_i = 1'b1;
            lk_hit_i   = 1'b0;
            lk_addr_i  = 32'h0000_4000 + 32'(m * 64);
            step();
            lk_valid_i = 1'b0;
            step();
        end
        n_checks++;
        if (lk_ready_o !== 1'b0 || dut.u_ctr.count_q !== 4'd4) begin
            n_fail++;
            $display("FAIL cap_full: ready=%b outst=%0d required 0 4", lk_ready_o, dut.u_ctr.count_q);
        end
        lk_valid_i = 1'b1;
        lk_hit_i   = 1'b1;
        step();
        lk_valid_i = 1'b0;
        n_checks++;
        if (hit_flag_fifo_wren_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_blocked: flag wren=%b required 0", hit_flag_fifo_wren_o);
        end
        pulse_rlast();
        n_checks++;
        if (lk_ready_o !== 1'b1 || dut.u_ctr.count_q !== 4'd3) begin
            n_fail++;
            $display("FAIL cap_release: ready=%b outst=%0d required 1 3", lk_ready_o, dut.u_ctr.count_q);
        end
        mem_arready_i = 1'b0;
        $display("cap: 4 misses outstanding then one retire");
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_arready_i = 1'b1;
        for (int m = 0; m < 2; m++) begin
            wait_ready("simul");
            lk_valid_i = 1'b1;
            lk_hit_i   = 1'b0;
            lk_addr_i  = 32'h0000_8000 + 32'(m * 64);
            step();
            lk_valid_i = 1'b0;
            step();
        end
        mem_arready_i = 1'b0;
        wait_ready("simul3");
        lk_valid_i = 1'b1;
        lk_hit_i   = 1'b0;
        lk_addr_i  = 32'h0000_8080;
        step();
        lk_valid_i = 1'b0;
        n_checks++;
        if (mem_arvalid_o !== 1'b1 || dut.u_ctr.count_q !== 4'd2) begin
            n_fail++;
            $display("FAIL simul_pre: arvalid=%b outst=%0d required 1 2", mem_arvalid_o, dut.u_ctr.count_q);
        end
        mem_arready_i = 1'b1;
        pulse_rlast();
        mem_arready_i = 1'b0;
        n_checks++;
        if (dut.u_ctr.count_q !== 4'd2 || mem_arvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_hs_retire: outst=%0d arvalid=%b required 2 0", dut.u_ctr.count_q, mem_arvalid_o);
        end
        $display("simultaneous: AR handshake with rlast at outstanding=2");
    endtask

    task automatic test_backpressure();
        do_reset();
        lk_valid_i            = 1'b1;
        lk_hit_i              = 1'b1;
        lk_addr_i             = 32'h0000_0100;
        lk_line_i             = {16{32'hDEAD_BEEF}};
        hit_data_fifo_afull_i = 1'b1;
        #1;
        n_checks++;
        if (lk_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_data_ready: ready=%b required 0", lk_ready_o);
        end
        step();
        n_checks++;
        if (hit_flag_fifo_wren_o !== 1'b0 || hit_data_fifo_wren_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_write: flag=%b data=%b required 0 0", hit_flag_fifo_wren_o, hit_data_fifo_wren_o);
        end
        hit_data_fifo_afull_i = 1'b0;
        hit_flag_fifo_afull_i = 1'b1;
        #1;
        n_checks++;
        if (lk_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_flag_ready: ready=%b required 0", lk_ready_o);
        end
        hit_flag_fifo_afull_i = 1'b0;
        #1;
        n_checks++;
        if (lk_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: ready=%b required 1", lk_ready_o);
        end
        step();
        lk_valid_i            = 1'b0;
        hit_data_fifo_afull_i = 1'b1;
        #1;
        n_checks++;
        if (hit_flag_fifo_wren_o !== 1'b1 || hit_data_fifo_wren_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_write: flag=%b data=%b required 1 1", hit_flag_fifo_wren_o, hit_data_fifo_wren_o);
        end
        hit_data_fifo_afull_i = 1'b0;
        $display("backpressure: data/flag afull block, release accepts");
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq;
        logic [CNT_W-1:0] exp_hits;
        logic [CNT_W-1:0] exp_miss;
        seq = 4'b1101;
        do_reset();
        mem_arready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lk_valid_i = 1'b1;
            lk_hit_i   = seq[3-k];
            lk_addr_i  = 32'h0001_0000 + 32'(k * 64) + 32'(k);
            lk_line_i  = {64{8'(k)}};
            #1;
            wait_ready("mixed");
            step();
            n_checks++;
            if (hit_flag_fifo_wren_o !== 1'b1 || hit_flag_fifo_wdata_o !== seq[3-k]) begin
                n_fail++;
                $display("FAIL mixed_flag[%0d]: wren=%b wdata=%b required 1 %b",
                         k, hit_flag_fifo_wren_o, hit_flag_fifo_wdata_o, seq[3-k]);
            end
            $display("mixed[%0d]: hit=%b flag=%b", k, seq[3-k], hit_flag_fifo_wdata_o);
        end
        lk_valid_i    = 1'b0;
        mem_arready_i = 1'b0;
        step();
`ifdef CC_DISPATCH_PERF_CNT_EN
        exp_hits = 32'd3;
        exp_miss = 32'd1;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif
        n_checks++;
        if (hit_cnt_o !== exp_hits || miss_cnt_o !== exp_miss) begin
            n_fail++;
            $display("FAIL mixed_counters: hit=%0d miss=%0d required %0d %0d",
                     hit_cnt_o, miss_cnt_o, exp_hits, exp_miss);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_cap();
        test_simultaneous();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
